// File: rtl/fp8_dot_accum_ctrl_if.sv
// Product-term stream in and dot-product result stream out for fp8_dot_accum_ctrl.
// Pure wiring, no latency.
// Both directions use valid/ready; the slave side is the accumulator controller.
interface fp8_dot_accum_ctrl_if #(
   parameter int IDX_W = 4
);
   logic             in_vld;
   logic [7:0]       in_dat;
   logic             in_rdy;
   logic             out_vld;
   logic [7:0]       out_dat;
   logic [IDX_W-1:0] out_idx;
   logic             out_rdy;

   modport master (
      output in_vld, in_dat, out_rdy,
      input  in_rdy, out_vld, out_dat, out_idx
   );

   modport slave (
      input  in_vld, in_dat, out_rdy,
      output in_rdy, out_vld, out_dat, out_idx
   );
endinterface

// File: rtl/fp8_dot_accum_ctrl.sv
// Sequences an external combinational FP8 adder to fold VEC_LEN product terms into one dot-product result.
// Result valid the cycle after the last term is accepted; at most one term per cycle.
// Holds the result (in_rdy low) until out_rdy; no combinational path from in_vld/out_rdy to outputs.
module fp8_dot_accum_ctrl #(
   parameter int VEC_LEN = 2,
   parameter int IDX_W   = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clear,
   fp8_dot_accum_ctrl_if.slave      s_if,
   output logic [7:0]               o_add_x,
   output logic [7:0]               o_add_y,
   input  logic [7:0]               i_add_z,
   output logic                     o_busy
);
   localparam int CNT_W = $clog2(VEC_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

   typedef enum logic [0:0] {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_acc;
   logic [7:0]       w_acc_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;

   // Adder operands are driven constantly; the sum is only captured on an accept.
   assign o_add_x = r_acc;
   assign o_add_y = s_if.in_dat;

   // Every output decodes from registers only.
   assign s_if.in_rdy  = (r_state == ST_ACC);
   assign s_if.out_vld = (r_state == ST_DONE);
   assign s_if.out_dat = r_acc;
   assign s_if.out_idx = r_idx;
   assign o_busy       = (r_cnt != '0) || (r_state == ST_DONE);

   // State register; reset wins over everything, including clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_ACC;
         r_acc   <= 8'h00;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next-state: accumulate terms in ACC, present and hold the result in DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_ACC: begin
            if (i_clear) begin
               // A term offered alongside clear is dropped even though in_rdy is high.
               w_acc_nxt = 8'h00;
               w_cnt_nxt = '0;
            end else if (s_if.in_vld) begin
               w_acc_nxt = i_add_z;
               if (r_cnt == LAST_CNT) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (i_clear) begin
               // Result discarded: index is not consumed.
               w_acc_nxt   = 8'h00;
               w_state_nxt = ST_ACC;
            end else if (s_if.out_rdy) begin
               // Zero is FP zero, so the next first term passes through the adder unchanged.
               w_acc_nxt   = 8'h00;
               w_idx_nxt   = r_idx + 1'b1;
               w_state_nxt = ST_ACC;
            end
         end
         default: begin
            w_state_nxt = ST_ACC;
         end
      endcase
   end
endmodule

// File: tb/tb_fp8_dot_accum_ctrl.sv
// Randomised plus directed bench for fp8_dot_accum_ctrl, adder modelled as z = x ^ y.
// A transaction-level model predicts results into a scoreboard; a monitor pops on each handshake.
// Per-cycle checks cover handshake levels, busy, and result stability under backpressure.
module tb_fp8_dot_accum_ctrl;
   localparam int VL = 2;
   localparam int IW = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic [7:0] add_x;
   logic [7:0] add_y;
   logic [7:0] add_z;
   logic       busy;

   fp8_dot_accum_ctrl_if #(.IDX_W(IW)) s_if ();

   fp8_dot_accum_ctrl #(.VEC_LEN(VL), .IDX_W(IW)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clear (clear),
      .s_if    (s_if),
      .o_add_x (add_x),
      .o_add_y (add_y),
      .i_add_z (add_z),
      .o_busy  (busy)
   );

   assign add_z = add_x ^ add_y;

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_out = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the list of terms gathered so far and whether a result is pending.
   logic [7:0]    m_terms[$];
   bit            m_done  = 1'b0;
   bit            m_valid = 1'b0;
   logic [7:0]    m_res;
   int            m_idx;
   logic [IW+7:0] sb[$];

   always @(negedge clk) begin : model
      if (m_valid) begin
         chk("in_rdy", 32'(s_if.in_rdy), 32'(!m_done));
         chk("out_vld", 32'(s_if.out_vld), 32'(m_done));
         chk("busy", 32'(busy), 32'((m_terms.size() != 0) || m_done));
         chk("add_y", 32'(add_y), 32'(s_if.in_dat));
         if (m_done) begin
            chk("out_dat_hold", 32'(s_if.out_dat), 32'(m_res));
            chk("out_idx_hold", 32'(s_if.out_idx), 32'(m_idx % (2 ** IW)));
         end
      end
      if (rst) begin
         m_terms.delete();
         sb.delete();
         m_done  = 1'b0;
         m_idx   = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (!m_done) begin
            if (clear) begin
               m_terms.delete();
            end else if (s_if.in_vld) begin
               m_terms.push_back(s_if.in_dat);
               if (m_terms.size() == VL) begin
                  m_res = 8'h00;
                  foreach (m_terms[k]) m_res = m_res ^ m_terms[k];
                  sb.push_back({m_res, IW'(m_idx)});
                  m_terms.delete();
                  m_done = 1'b1;
               end
            end
         end else begin
            if (clear) begin
               m_done = 1'b0;
               void'(sb.pop_back());
            end else if (s_if.out_rdy) begin
               m_done = 1'b0;
               m_idx++;
            end
         end
      end
   end

   // Monitor: every completed handshake must match the oldest predicted result.
   always @(negedge clk) begin : monitor
      logic [IW+7:0] e;
      if (m_valid && !rst && !clear && s_if.out_vld && s_if.out_rdy) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got dat %0h idx %0h want no result", s_if.out_dat, s_if.out_idx);
         end else begin
            e = sb.pop_front();
            chk("out_dat", 32'(s_if.out_dat), 32'(e[IW+7:IW]));
            chk("out_idx", 32'(s_if.out_idx), 32'(e[IW-1:0]));
            n_out++;
         end
      end
   end

   task automatic cyc(input bit r, input bit c, input bit v, input logic [7:0] d, input bit ordy);
      rst          = r;
      clear        = c;
      s_if.in_vld  = v;
      s_if.in_dat  = d;
      s_if.out_rdy = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit ordy);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, ordy);
   endtask

   task automatic term(input logic [7:0] d);
      cyc(1'b0, 1'b0, 1'b1, d, 1'b1);
   endtask

   initial begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      idle(1'b0);

      // Basic back-to-back pair, then a second result with the next index.
      term(8'h35); term(8'h0A); idle(1'b1);
      term(8'h12); term(8'h34); idle(1'b1);

      // Backpressure with in_vld held high throughout DONE.
      term(8'h44); term(8'h55);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
      idle(1'b1);

      // Gapped input.
      term(8'h11); idle(1'b1); idle(1'b1); idle(1'b1); term(8'h22); idle(1'b1);

      // Abort in ACC with a term on the same cycle.
      term(8'h7F); cyc(1'b0, 1'b1, 1'b1, 8'h01, 1'b1);
      term(8'h05); term(8'h06); idle(1'b1);

      // Index wrap across five results.
      for (int i = 0; i < 5; i++) begin
         term(8'($urandom)); term(8'($urandom)); idle(1'b1);
      end

      // Clear while a result is pending.
      term(8'hA0); term(8'h0B); cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      term(8'h01); term(8'h02); idle(1'b1);

      // Reset mid-vector, and again while holding a result.
      term(8'h21); cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); idle(1'b0);
      term(8'h31); term(8'h42); idle(1'b0);
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); idle(1'b0); idle(1'b0);
      term(8'h0F); term(8'hF0); idle(1'b1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
             8'($urandom), ($urandom % 3) != 0);
      end

      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
